// File: rtl/par_ser_pkg.sv
// Shared types and constants for the parallel-to-serial converter arbiter.
package par_ser_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    WAIT_CMP = 2'd2,
    ACK      = 2'd3
  } state_e;

  localparam int unsigned SER_W         = 44;
  localparam int unsigned SER_FRAME_CYC = 51;

  // Increment with wrap at n, used for the round-robin pointer.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/par_ser_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = 1'b0;
    w_sum  = '0;
    w_cand = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
      if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (!valid && req[w_cand]) begin
        valid          = 1'b1;
        winner[w_cand] = 1'b1;
        idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/par_ser_arb.sv
// Round-robin scheduler sharing one parallel-to-serial converter among NUM_REQ producers.
// Optional WAIT_CMP watchdog enabled by defining PAR_SER_ARB_TIMEOUT_EN.
module par_ser_arb
  import par_ser_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned DATA_W      = SER_W,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      g_rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic                      par_ser_intl,
  output logic [DATA_W-1:0]         par_ser_data,
  output logic                      tx_success,
  input  logic                      tx_pcrc_intl,
  input  logic                      tx_pcrc_frm_cmp,
  output logic                      err_timeout
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("par_ser_arb: NUM_REQ must be 2..8");
  end
  if (DATA_W != SER_W) begin : g_bad_data_w
    $error("par_ser_arb: DATA_W must equal the converter width");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("par_ser_arb: TIMEOUT_CYC must fit the 8-bit watchdog");
  end

  state_e              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]  r_done, w_done_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_intl, w_intl_nxt;
  logic                r_txs, w_txs_nxt;
  logic                r_err, w_err_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;

  logic [NUM_REQ-1:0]  w_win;
  logic [IDX_W-1:0]    w_win_idx;
  logic                w_win_vld;
  logic                w_timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req    (req),
    .rr_ptr (r_ptr),
    .winner (w_win),
    .idx    (w_win_idx),
    .valid  (w_win_vld)
  );

`ifdef PAR_SER_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] r_cnt;

  // Counts cycles already spent in WAIT_CMP; cleared in every other state.
  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      r_cnt <= '0;
    end else if (r_state != WAIT_CMP) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_state == WAIT_CMP) && (r_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_intl_nxt  = 1'b0;
    w_txs_nxt   = 1'b0;
    w_data_nxt  = r_data;
    w_err_nxt   = r_err;

    unique case (r_state)
      IDLE: begin
        if (w_win_vld && tx_pcrc_intl) begin
          w_state_nxt = START;
          w_idx_nxt   = w_win_idx;
          w_gnt_nxt   = w_win;
          w_intl_nxt  = 1'b1;
          w_err_nxt   = 1'b0;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) begin
              w_data_nxt = req_data[i*DATA_W +: DATA_W];
            end
          end
        end
      end
      START: begin
        w_state_nxt = WAIT_CMP;
      end
      WAIT_CMP: begin
        if (tx_pcrc_frm_cmp || w_timeout) begin
          w_state_nxt = ACK;
          w_txs_nxt   = 1'b1;
          w_done_nxt  = r_gnt;
          if (!tx_pcrc_frm_cmp) begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ACK: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_ptr_nxt   = IDX_W'(wrap_inc(32'(r_idx), NUM_REQ));
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_intl  <= 1'b0;
      r_txs   <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_intl  <= w_intl_nxt;
      r_txs   <= w_txs_nxt;
      r_err   <= w_err_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign gnt          = r_gnt;
  assign done         = r_done;
  assign busy         = r_busy;
  assign par_ser_intl = r_intl;
  assign par_ser_data = r_data;
  assign tx_success   = r_txs;
  assign err_timeout  = r_err;

endmodule

// File: tb/tb_par_ser_arb.sv
// Self-checking bench for par_ser_arb with a behavioural converter model.
module tb_par_ser_arb;
  import par_ser_pkg::*;

  localparam int unsigned N = 3;
  localparam int unsigned W = SER_W;

  localparam logic [W-1:0] D0 = 44'hABC_DEF0_1234;
  localparam logic [W-1:0] D1 = 44'h123_4567_89AB;
  localparam logic [W-1:0] D2 = 44'hFED_CBA9_8765;

  logic           clk = 1'b0;
  logic           g_rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic           par_ser_intl;
  logic [W-1:0]   par_ser_data;
  logic           tx_success;
  logic           tx_pcrc_intl;
  logic           tx_pcrc_frm_cmp;
  logic           err_timeout;

  always #5 clk = ~clk;

  par_ser_arb #(
    .NUM_REQ     (N),
    .DATA_W      (W),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk             (clk),
    .g_rst_n         (g_rst_n),
    .req             (req),
    .req_data        (req_data),
    .gnt             (gnt),
    .done            (done),
    .busy            (busy),
    .par_ser_intl    (par_ser_intl),
    .par_ser_data    (par_ser_data),
    .tx_success      (tx_success),
    .tx_pcrc_intl    (tx_pcrc_intl),
    .tx_pcrc_frm_cmp (tx_pcrc_frm_cmp),
    .err_timeout     (err_timeout)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitors
  int cyc = 0;
  int frm_cyc = 0;
  int intl_pulses = 0;
  int done_pulses = 0;
  int onehot_viol = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (tx_pcrc_frm_cmp === 1'b1) frm_cyc = cyc;
    if (par_ser_intl === 1'b1) intl_pulses++;
    if (done !== '0) done_pulses++;
    if ($countones(gnt) > 1) onehot_viol++;
  end

  // Converter model: start seen after E0, 44 serial bits, frm_cmp after E47, idle after E50.
  bit           model_en;
  int           cv_cnt = -1;
  logic [W-1:0] cv_sh;
  logic [W-1:0] ser_word;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!model_en) begin
        cv_cnt = -1;
      end else if (cv_cnt < 0) begin
        if (par_ser_intl === 1'b1) begin
          cv_cnt       = 0;
          cv_sh        = par_ser_data;
          ser_word     = '0;
          tx_pcrc_intl = 1'b0;
        end
      end else begin
        cv_cnt++;
        if (cv_cnt >= 1 && cv_cnt <= 44) begin
          ser_word = {ser_word[W-2:0], cv_sh[W-1]};
          cv_sh    = cv_sh << 1;
        end
        if (cv_cnt == 47) tx_pcrc_frm_cmp = 1'b1;
        if (cv_cnt == 48) tx_pcrc_frm_cmp = 1'b0;
        if (cv_cnt == 50) begin
          tx_pcrc_intl = 1'b1;
          cv_cnt       = -1;
        end
      end
    end
  end

  task automatic wait_gnt(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (gnt !== '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no grant within 200 cycles", nm);
    end
  endtask

  task automatic wait_done(input string nm, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (done !== '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no done within 300 cycles", nm);
    end
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] exp_gnt;
    logic [W-1:0] exp_word;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit ok;
    int n;
    int g_cyc;
    int prev_g;
    int pulse_base;
    int done_base;
    int exp_done;

    // Expected grants follow the pointer: 0 after reset, then idx+1 after each frame.
    tbl[0] = '{req: 3'b001, exp_gnt: 3'b001, exp_word: D0};
    tbl[1] = '{req: 3'b111, exp_gnt: 3'b010, exp_word: D1};
    tbl[2] = '{req: 3'b111, exp_gnt: 3'b100, exp_word: D2};
    tbl[3] = '{req: 3'b111, exp_gnt: 3'b001, exp_word: D0};
    tbl[4] = '{req: 3'b111, exp_gnt: 3'b010, exp_word: D1};
    tbl[5] = '{req: 3'b101, exp_gnt: 3'b100, exp_word: D2};
    tbl[6] = '{req: 3'b110, exp_gnt: 3'b010, exp_word: D1};
    tbl[7] = '{req: 3'b011, exp_gnt: 3'b001, exp_word: D0};
    tbl[8] = '{req: 3'b001, exp_gnt: 3'b001, exp_word: D0};
    tbl[9] = '{req: 3'b100, exp_gnt: 3'b100, exp_word: D2};

    exp_done        = 0;
    prev_g          = 0;
    req             = '0;
    req_data        = {D2, D1, D0};
    g_rst_n         = 1'b0;
    model_en        = 1'b1;
    tx_pcrc_intl    = 1'b1;
    tx_pcrc_frm_cmp = 1'b0;
    ser_word        = '0;

    repeat (3) @(negedge clk);
    chk("reset_gnt",  64'(gnt), 0);
    chk("reset_done", 64'(done), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_intl", 64'(par_ser_intl), 0);
    chk("reset_data", 64'(par_ser_data), 0);
    chk("reset_txs",  64'(tx_success), 0);
    chk("reset_err",  64'(err_timeout), 0);
    g_rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      pulse_base = intl_pulses;
      req        = tbl[i].req;
      wait_gnt($sformatf("tbl%0d_gnt_wait", i), ok);
      if (ok) begin
        g_cyc = cyc;
        chk($sformatf("tbl%0d_gnt", i),  64'(gnt), 64'(tbl[i].exp_gnt));
        chk($sformatf("tbl%0d_word", i), 64'(par_ser_data), 64'(tbl[i].exp_word));
        chk($sformatf("tbl%0d_busy", i), 64'(busy), 1);
        if (i > 0) chk($sformatf("tbl%0d_spacing", i), 64'(g_cyc - prev_g >= int'(SER_FRAME_CYC)), 1);
        prev_g = g_cyc;
        wait_done($sformatf("tbl%0d_done_wait", i), ok, n);
        exp_done++;
        chk($sformatf("tbl%0d_done", i),     64'(done), 64'(tbl[i].exp_gnt));
        chk($sformatf("tbl%0d_txs", i),      64'(tx_success), 1);
        chk($sformatf("tbl%0d_serial", i),   64'(ser_word), 64'(tbl[i].exp_word));
        chk($sformatf("tbl%0d_data_hold", i), 64'(par_ser_data), 64'(tbl[i].exp_word));
        chk($sformatf("tbl%0d_gnt_hold", i), 64'(gnt), 64'(tbl[i].exp_gnt));
        chk($sformatf("tbl%0d_cmp_lat", i),  64'(cyc - frm_cyc), 1);
        chk($sformatf("tbl%0d_intl_cnt", i), 64'(intl_pulses - pulse_base), 1);
        @(negedge clk);
        chk($sformatf("tbl%0d_done_off", i), 64'(done), 0);
        chk($sformatf("tbl%0d_txs_off", i),  64'(tx_success), 0);
        chk($sformatf("tbl%0d_gnt_off", i),  64'(gnt), 0);
        chk($sformatf("tbl%0d_idle", i),     64'(busy), 0);
      end
    end
    req = '0;

    // req[1] dropped mid-transfer; data change after grant must not leak in.
    req = 3'b010;
    wait_gnt("drop_gnt_wait", ok);
    chk("drop_gnt", 64'(gnt), 64'(3'b010));
    repeat (10) @(negedge clk);
    req      = '0;
    req_data = {D2, ~D1, D0};
    wait_done("drop_done_wait", ok, n);
    exp_done++;
    chk("drop_done", 64'(done), 64'(3'b010));
    chk("drop_data", 64'(par_ser_data), 64'(D1));
    @(negedge clk);
    req_data = {D2, D1, D0};
    req      = 3'b111;
    wait_gnt("drop_ptr_wait", ok);
    chk("drop_ptr_gnt", 64'(gnt), 64'(3'b100));
    wait_done("drop_ptr_done_wait", ok, n);
    exp_done++;
    chk("drop_ptr_done", 64'(done), 64'(3'b100));
    @(negedge clk);
    req = '0;

    // Manual converter: frm_cmp in IDLE and START must be ignored; IDLE gated by tx_pcrc_intl.
    repeat (3) @(negedge clk);
    model_en        = 1'b0;
    @(negedge clk);
    tx_pcrc_intl    = 1'b0;
    tx_pcrc_frm_cmp = 1'b1;
    req             = 3'b001;
    repeat (5) @(negedge clk);
    chk("gate_gnt",  64'(gnt), 0);
    chk("gate_busy", 64'(busy), 0);
    chk("idle_cmp_txs",  64'(tx_success), 0);
    chk("idle_cmp_done", 64'(done), 0);
    tx_pcrc_frm_cmp = 1'b0;
    tx_pcrc_intl    = 1'b1;
    wait_gnt("start_gnt_wait", ok);
    chk("start_gnt",  64'(gnt), 64'(3'b001));
    chk("start_intl", 64'(par_ser_intl), 1);
    tx_pcrc_frm_cmp = 1'b1;
    @(negedge clk);
    tx_pcrc_frm_cmp = 1'b0;
    chk("start_cmp_txs",  64'(tx_success), 0);
    chk("start_cmp_done", 64'(done), 0);
    chk("start_cmp_busy", 64'(busy), 1);
    chk("start_intl_off", 64'(par_ser_intl), 0);
    repeat (3) @(negedge clk);
    chk("wait_hold_txs", 64'(tx_success), 0);
    chk("wait_hold_gnt", 64'(gnt), 64'(3'b001));
    tx_pcrc_frm_cmp = 1'b1;
    @(negedge clk);
    tx_pcrc_frm_cmp = 1'b0;
    exp_done++;
    chk("manual_done", 64'(done), 64'(3'b001));
    chk("manual_txs",  64'(tx_success), 1);
    @(negedge clk);
    chk("manual_idle", 64'(busy), 0);
    req = '0;

    // Async reset mid-transfer aborts without done; pointer returns to 0.
    model_en = 1'b1;
    @(negedge clk);
    req = 3'b100;
    wait_gnt("rst_gnt_wait", ok);
    chk("rst_pre_gnt", 64'(gnt), 64'(3'b100));
    repeat (10) @(negedge clk);
    done_base = done_pulses;
    model_en  = 1'b0;
    g_rst_n   = 1'b0;
    #1;
    chk("rst_gnt",  64'(gnt), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_data", 64'(par_ser_data), 0);
    chk("rst_txs",  64'(tx_success), 0);
    repeat (3) @(negedge clk);
    tx_pcrc_intl    = 1'b1;
    tx_pcrc_frm_cmp = 1'b0;
    model_en        = 1'b1;
    req             = 3'b011;
    g_rst_n         = 1'b1;
    wait_gnt("rst_post_wait", ok);
    chk("rst_no_done", 64'(done_pulses - done_base), 0);
    chk("rst_ptr_gnt", 64'(gnt), 64'(3'b001));
    wait_done("rst_post_done_wait", ok, n);
    exp_done++;
    chk("rst_post_done", 64'(done), 64'(3'b001));
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);

`ifdef PAR_SER_ARB_TIMEOUT_EN
    // Watchdog: 64 WAIT_CMP cycles without frm_cmp force ACK with err_timeout.
    model_en        = 1'b0;
    tx_pcrc_intl    = 1'b1;
    tx_pcrc_frm_cmp = 1'b0;
    req             = 3'b001;
    wait_gnt("to_gnt_wait", ok);
    chk("to_gnt", 64'(gnt), 64'(3'b001));
    repeat (64) @(negedge clk);
    chk("to_err_early",  64'(err_timeout), 0);
    chk("to_done_early", 64'(done), 0);
    @(negedge clk);
    exp_done++;
    chk("to_done", 64'(done), 64'(3'b001));
    chk("to_txs",  64'(tx_success), 1);
    chk("to_err",  64'(err_timeout), 1);
    @(negedge clk);
    chk("to_err_sticky", 64'(err_timeout), 1);
    chk("to_idle",       64'(busy), 0);
    model_en = 1'b1;
    req      = 3'b010;
    wait_gnt("to_next_wait", ok);
    chk("to_next_gnt", 64'(gnt), 64'(3'b010));
    chk("to_err_clr",  64'(err_timeout), 0);
    wait_done("to_next_done_wait", ok, n);
    exp_done++;
    chk("to_next_done", 64'(done), 64'(3'b010));
    @(negedge clk);
    req = '0;
`else
    chk("err_tied_low", 64'(err_timeout), 0);
`endif

    chk("gnt_onehot",  64'(onehot_viol), 0);
    chk("done_pulses", 64'(done_pulses), 64'(exp_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
